pipelined_rca: RTL and testbench

//  Parametrised, pipelined ripple-carry adder/subtractor: N-bit operands split into STAGES chunks,

---
 rtl/rca_pkg.sv | 19 +
 rtl/full_adder.sv | 13 +
 rtl/rca_chunk.sv | 28 ++
 rtl/pipelined_rca.sv | 129 ++++++++++++
 tb/tb_pipelined_rca.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/rca_pkg.sv
// Shared constants and helpers for the pipelined ripple-carry adder.
// Build option OVERFLOW_FLAG_EN adds a registered signed-overflow output.
package rca_pkg;

  function automatic bit stages_legal(input int unsigned n, input int unsigned stages);
    return (stages != 0) && (n != 0) && (n % stages == 0);
  endfunction

  function automatic int unsigned chunk_width(input int unsigned n, input int unsigned stages);
    return (stages == 0) ? n : n / stages;
  endfunction

  // Per-stage control record; data slices are sized per stage in the top module.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_chunk.sv
// W-bit combinational ripple-carry chain built from full_adder cells.
module rca_chunk #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .sum (sum[i]),
      .cout(c[i+1])
    );
  end

  assign cout = c[W];

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor, one W-bit chunk per stage, valid/ready handshake.
// Define OVERFLOW_FLAG_EN to add the registered signed-overflow output.
module pipelined_rca
  import rca_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
`ifdef OVERFLOW_FLAG_EN
  output logic         overflow,
`endif
  output logic         carry
);

  localparam int unsigned W = chunk_width(N, STAGES);

  if (!stages_legal(N, STAGES)) begin : g_bad_cfg
    $error("pipelined_rca: N must be a nonzero multiple of STAGES");
  end

  logic         advance;
  logic [N-1:0] bp;

  // The whole pipe moves together; a stalled output freezes every stage.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign bp       = sub ? ~b : b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [W-1:0] ca, cb, cs;
    logic         ci, co, v_in;
    logic [N-1:0] s_base, s_d, s_q;
    stage_ctl_t   ctl_q;

    if (k == 0) begin : g_first
      assign ca     = a[W-1:0];
      assign cb     = bp[W-1:0];
      assign ci     = sub ? 1'b1 : cin;
      assign v_in   = in_valid;
      assign s_base = '0;
    end else begin : g_rest
      assign ca     = g_stage[k-1].g_pend.pa_q[W-1:0];
      assign cb     = g_stage[k-1].g_pend.pb_q[W-1:0];
      assign ci     = g_stage[k-1].ctl_q.carry;
      assign v_in   = g_stage[k-1].ctl_q.valid;
      assign s_base = g_stage[k-1].s_q;
    end

    rca_chunk #(.W(W)) u_chunk (
      .a   (ca),
      .b   (cb),
      .cin (ci),
      .sum (cs),
      .cout(co)
    );

    always_comb begin
      s_d           = s_base;
      s_d[k*W +: W] = cs;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ctl_q <= '0;
        s_q   <= '0;
      end else if (advance) begin
        ctl_q <= '{valid: v_in, carry: co};
        s_q   <= s_d;
      end
    end

    // Operand bits not yet consumed travel with the beat, low chunk first.
    if (k < STAGES - 1) begin : g_pend
      localparam int unsigned R = N - (k + 1) * W;
      logic [R-1:0] pa_d, pb_d, pa_q, pb_q;

      if (k == 0) begin : g_src_in
        assign pa_d = a[N-1:W];
        assign pb_d = bp[N-1:W];
      end else begin : g_src_pipe
        assign pa_d = g_stage[k-1].g_pend.pa_q[R+W-1:W];
        assign pb_d = g_stage[k-1].g_pend.pb_q[R+W-1:W];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pa_q <= '0;
          pb_q <= '0;
        end else if (advance) begin
          pa_q <= pa_d;
          pb_q <= pb_d;
        end
      end
    end

`ifdef OVERFLOW_FLAG_EN
    // The last chunk's operand MSBs are a[N-1] and b'[N-1].
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= (ca[W-1] == cb[W-1]) && (cs[W-1] != ca[W-1]);
        end
      end
    end
`endif
  end

  assign out_valid = g_stage[STAGES-1].ctl_q.valid;
  assign carry     = g_stage[STAGES-1].ctl_q.carry;
  assign sum       = g_stage[STAGES-1].s_q;
`ifdef OVERFLOW_FLAG_EN
  assign overflow  = g_stage[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_rca.sv
// Directed self-checking bench for pipelined_rca (N=8, STAGES=2; N=16/STAGES=4 with OVERFLOW_FLAG_EN).
module tb_pipelined_rca;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, sum;
  logic       cin, sub, carry;
  int         n_pass = 0;
  int         n_total = 0;
  int         first_cyc;

  always #5 clk = ~clk;

`ifdef OVERFLOW_FLAG_EN
  logic        ovf8;
  logic        in_valid16, in_ready16, out_valid16, carry16, ovf16;
  logic [15:0] a16, b16, sum16;
  logic        sub16;

  pipelined_rca #(.N(16), .STAGES(4)) u_dut16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid16),
    .in_ready (in_ready16),
    .a        (a16),
    .b        (b16),
    .cin      (1'b0),
    .sub      (sub16),
    .out_valid(out_valid16),
    .out_ready(1'b1),
    .sum      (sum16),
    .overflow (ovf16),
    .carry    (carry16)
  );
`endif

  pipelined_rca #(.N(8), .STAGES(2)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
`ifdef OVERFLOW_FLAG_EN
    .overflow (ovf8),
`endif
    .carry    (carry)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // Golden {carry, sum}: subtract is a + ~b + 1, so carry is not-borrow.
  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic c, input logic s);
    return s ? ({1'b0, x} + {1'b0, ~y} + 9'd1) : ({1'b0, x} + {1'b0, y} + {8'd0, c});
  endfunction

  task automatic send(input string tag, input logic [7:0] x, input logic [7:0] y,
                      input logic c, input logic s, input logic [8:0] exp);
    @(negedge clk);
    in_valid = 1'b1; a = x; b = y; cin = c; sub = s; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_lat"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sum"}, 32'(sum), 32'(exp[7:0]));
    chk({tag, "_carry"}, 32'(carry), 32'(exp[8]));
  endtask

  // Random stream with an optional out_ready=0 window over cycles [st_lo, st_hi].
  task automatic run_stream(input string tag, input int nbeats, input int st_lo,
                            input int st_hi, output int first);
    logic [8:0] q[$];
    logic [8:0] exp;
    logic [7:0] held = '0;
    bit         hold_v = 1'b0;
    int         sent = 0;
    int         got = 0;
    first = -1;
    for (int c = 0; c < nbeats + 40 && got < nbeats; c++) begin
      @(negedge clk);
      out_ready = !(c >= st_lo && c <= st_hi);
      if (sent < nbeats) begin
        in_valid = 1'b1;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && !out_ready) begin
        chk({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
        if (hold_v) chk({tag, "_stall_sum"}, 32'(sum), 32'(held));
        held = sum; hold_v = 1'b1;
      end else begin
        hold_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (first < 0) first = c;
        exp = (q.size() > 0) ? q.pop_front() : 9'bx;
        chk({tag, "_result"}, 32'({carry, sum}), 32'(exp));
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, cin, sub));
        sent++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk({tag, "_count"}, 32'(got), 32'(nbeats));
    chk({tag, "_leftover"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
`ifdef OVERFLOW_FLAG_EN
    in_valid16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    send("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 9'h010);
    send("add_ff_01_c", 8'hFF, 8'h01, 1'b1, 1'b0, 9'h101);
    send("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 9'h0FE);
    send("sub_07_05", 8'h07, 8'h05, 1'b0, 1'b1, 9'h102);
    send("sub_cin_ignored", 8'h05, 8'h05, 1'b1, 1'b1, 9'h100);
    send("add_80_80", 8'h80, 8'h80, 1'b0, 1'b0, 9'h100);
    @(negedge clk);
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    run_stream("stream", 16, -1, -2, first_cyc);
    chk("stream_first_cycle", 32'(first_cyc), 32'd2);
    repeat (2) @(negedge clk);
    run_stream("bp", 8, 4, 6, first_cyc);
    repeat (2) @(negedge clk);

    // Two beats in flight, then asynchronous reset between clock edges.
    @(negedge clk);
    in_valid = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    a = 8'h33; b = 8'h44;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_output", 32'(out_valid), 32'd0);
    end

`ifdef OVERFLOW_FLAG_EN
    @(negedge clk);
    in_valid16 = 1'b1; a16 = 16'h7FFF; b16 = 16'h0001; sub16 = 1'b0;
    @(negedge clk);
    in_valid16 = 1'b1; a16 = 16'h8000; b16 = 16'h0001; sub16 = 1'b1;
    @(negedge clk);
    in_valid16 = 1'b0;
    repeat (2) @(negedge clk);
    chk("ovf_add_valid", 32'(out_valid16), 32'd1);
    chk("ovf_add_sum", 32'(sum16), 32'h8000);
    chk("ovf_add_flag", 32'(ovf16), 32'd1);
    @(negedge clk);
    chk("ovf_sub_valid", 32'(out_valid16), 32'd1);
    chk("ovf_sub_sum", 32'(sum16), 32'h7FFF);
    chk("ovf_sub_flag", 32'(ovf16), 32'd1);
    chk("ovf_sub_carry", 32'(carry16), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
